// File: rtl/pmi_distributed_shift_reg_if.sv
// Data-path bundle for pmi_distributed_shift_reg: enable, data in, tap address and delayed output.
interface pmi_distributed_shift_reg_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              ClockEn;
  logic [DATA_W-1:0] Din;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Q;

  modport master (output ClockEn, Din, Addr, input Q);
  modport slave  (input ClockEn, Din, Addr, output Q);
endinterface

// File: rtl/pmi_distributed_shift_reg.sv
// LUT-RAM style shift register with fixed or Addr-selected tap and optional output register.
// Define PMI_SHIFT_RESET_ALL_EN to make Reset also clear every stage (flop-based build).
module pmi_distributed_shift_reg #(
  parameter int    pmi_data_width       = 8,
  parameter string pmi_regmode          = "reg",
  parameter string pmi_shiftreg_type    = "fixed",
  parameter int    pmi_num_shift        = 16,
  parameter int    pmi_num_width        = 4,
  parameter int    pmi_max_shift        = 16,
  parameter int    pmi_max_width        = 64,
  parameter string pmi_init_file        = "none",
  parameter string pmi_init_file_format = "binary",
  parameter string pmi_family           = "ECP5"
) (
  input  logic                         Clock,
  input  logic                         Reset,
  pmi_distributed_shift_reg_if.slave   bus
);
  localparam bit IS_FIXED = (pmi_shiftreg_type == "fixed");
  localparam bit IS_REG   = (pmi_regmode == "reg");
  localparam int N        = IS_FIXED ? pmi_num_shift : pmi_max_shift;
  localparam int DEPTH    = (N < 1) ? 1 : N;

  if (pmi_data_width > pmi_max_width) begin : g_chk_width
    $fatal(1, "pmi_data_width exceeds pmi_max_width");
  end
  if (!IS_REG && pmi_regmode != "noreg") begin : g_chk_mode
    $fatal(1, "pmi_regmode must be reg or noreg");
  end
  if (!IS_FIXED && pmi_shiftreg_type != "variable") begin : g_chk_type
    $fatal(1, "pmi_shiftreg_type must be fixed or variable");
  end
  if (!IS_FIXED && pmi_max_shift < 1) begin : g_chk_depth
    $fatal(1, "variable type needs pmi_max_shift >= 1");
  end

  // Reset is only consumed in some builds; Addr only in variable type.
  logic unused_in;
  assign unused_in = ^{Reset, bus.Addr, 1'(pmi_family.len())};

  logic [pmi_data_width-1:0] s [DEPTH];
  logic [pmi_data_width-1:0] tap;

  always_ff @(posedge Clock) begin
`ifdef PMI_SHIFT_RESET_ALL_EN
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= '0;
    end else
`endif
    if (bus.ClockEn) begin
      s[0] <= bus.Din;
      for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
    end
  end

  if (IS_FIXED && N == 0) begin : g_tap_thru
    assign tap = bus.Din;
  end else if (IS_FIXED) begin : g_tap_fixed
    assign tap = s[N-1];
  end else begin : g_tap_var
    // Out-of-range addresses fall through to the deepest stage.
    always_comb begin
      tap = s[DEPTH-1];
      for (int i = 0; i < DEPTH; i++)
        if (32'(bus.Addr) == 32'(i)) tap = s[i];
    end
  end

  if (IS_REG) begin : g_out_reg
    logic [pmi_data_width-1:0] r;
    always_ff @(posedge Clock) begin
      if (Reset)            r <= '0;
      else if (bus.ClockEn) r <= tap;
    end
    assign bus.Q = r;
  end else begin : g_out_comb
    assign bus.Q = tap;
  end
endmodule

// File: tb/tb_pmi_distributed_shift_reg.sv
// Bench for pmi_distributed_shift_reg: five configurations share one stimulus stream and one history model.
module tb_pmi_distributed_shift_reg;
  logic       clk = 1'b0;
  logic       rst, ce;
  logic [7:0] din;
  logic [3:0] addr;
  int ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

  pmi_distributed_shift_reg_if #(.DATA_W(8), .ADDR_W(4)) ifA ();
  pmi_distributed_shift_reg_if #(.DATA_W(8), .ADDR_W(4)) ifB ();
  pmi_distributed_shift_reg_if #(.DATA_W(8), .ADDR_W(4)) ifC ();
  pmi_distributed_shift_reg_if #(.DATA_W(8), .ADDR_W(4)) ifD ();
  pmi_distributed_shift_reg_if #(.DATA_W(8), .ADDR_W(4)) ifE ();

  assign ifA.ClockEn = ce; assign ifA.Din = din; assign ifA.Addr = addr;
  assign ifB.ClockEn = ce; assign ifB.Din = din; assign ifB.Addr = addr;
  assign ifC.ClockEn = ce; assign ifC.Din = din; assign ifC.Addr = addr;
  assign ifD.ClockEn = ce; assign ifD.Din = din; assign ifD.Addr = addr;
  assign ifE.ClockEn = ce; assign ifE.Din = din; assign ifE.Addr = addr;

  // A: defaults (fixed, reg, 16)
  pmi_distributed_shift_reg uA (.Clock(clk), .Reset(rst), .bus(ifA.slave));
  // B: fixed, noreg, 3
  pmi_distributed_shift_reg #(.pmi_regmode("noreg"), .pmi_num_shift(3))
    uB (.Clock(clk), .Reset(rst), .bus(ifB.slave));
  // C: fixed, reg, 0
  pmi_distributed_shift_reg #(.pmi_num_shift(0))
    uC (.Clock(clk), .Reset(rst), .bus(ifC.slave));
  // D: fixed, reg, 4
  pmi_distributed_shift_reg #(.pmi_num_shift(4))
    uD (.Clock(clk), .Reset(rst), .bus(ifD.slave));
  // E: variable, noreg, 8
  pmi_distributed_shift_reg #(.pmi_regmode("noreg"), .pmi_shiftreg_type("variable"), .pmi_max_shift(8))
    uE (.Clock(clk), .Reset(rst), .bus(ifE.slave));

  // Reference: hist[k] is the word accepted k enabled edges ago; rX are output registers.
  logic [7:0] hist [64];
  logic [7:0] rA = 8'h00, rC = 8'h00, rD = 8'h00;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ftap(input int n);
    return (n == 0) ? din : hist[n-1];
  endfunction

  function automatic logic [7:0] vtap(input int n, input int a);
    return hist[(a >= n) ? n-1 : a];
  endfunction

  task automatic step(input logic r, input logic c, input logic [7:0] d, input logic [3:0] a);
    logic [7:0] nA, nC, nD;
    rst = r; ce = c; din = d; addr = a;
    nA = r ? 8'h00 : (c ? ftap(16) : rA);
    nC = r ? 8'h00 : (c ? ftap(0)  : rC);
    nD = r ? 8'h00 : (c ? ftap(4)  : rD);
    @(posedge clk); #1;
    rA = nA; rC = nC; rD = nD;
`ifdef PMI_SHIFT_RESET_ALL_EN
    if (r) begin
      for (int i = 0; i < 64; i++) hist[i] = 8'h00;
    end else
`endif
    if (c) begin
      for (int i = 63; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = d;
    end
    chk("model_A", ifA.Q, rA);
    chk("model_B", ifB.Q, hist[2]);
    chk("model_C", ifC.Q, rC);
    chk("model_D", ifD.Q, rD);
    chk("model_E", ifE.Q, vtap(8, int'(a)));
  endtask

  typedef struct {
    logic       rst;
    logic       ce;
    logic [7:0] din;
    logic [7:0] exp_b;
    logic [7:0] exp_c;
  } vec_t;

`ifdef PMI_SHIFT_RESET_ALL_EN
  localparam logic [7:0] B_RST = 8'h00, B_AFTER = 8'h00;
`else
  localparam logic [7:0] B_RST = 8'h33, B_AFTER = 8'h44;
`endif

  initial begin
    vec_t tbl [10];
    tbl[0] = '{1'b0, 1'b1, 8'h11, 8'h00, 8'h11};
    tbl[1] = '{1'b0, 1'b1, 8'h22, 8'h00, 8'h22};
    tbl[2] = '{1'b0, 1'b1, 8'h33, 8'h11, 8'h33};
    tbl[3] = '{1'b0, 1'b1, 8'h44, 8'h22, 8'h44};
    tbl[4] = '{1'b0, 1'b0, 8'h55, 8'h22, 8'h44};
    tbl[5] = '{1'b0, 1'b0, 8'h55, 8'h22, 8'h44};
    tbl[6] = '{1'b0, 1'b0, 8'h55, 8'h22, 8'h44};
    tbl[7] = '{1'b0, 1'b1, 8'h55, 8'h33, 8'h55};
    tbl[8] = '{1'b1, 1'b0, 8'h66, B_RST, 8'h00};
    tbl[9] = '{1'b0, 1'b1, 8'h77, B_AFTER, 8'h77};

    for (int i = 0; i < 64; i++) hist[i] = 8'h00;
    rst = 1'b1; ce = 1'b1; din = 8'h00; addr = 4'h0;

    // Flush every stage and output register to a known zero state.
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 8'h00, 4'h0);
    chk("reset_A", ifA.Q, 8'h00);
    chk("reset_D", ifD.Q, 8'h00);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].ce, tbl[i].din, 4'h0);
      chk($sformatf("tbl%0d_B", i), ifB.Q, tbl[i].exp_b);
      chk($sformatf("tbl%0d_C", i), ifC.Q, tbl[i].exp_c);
    end

    // Variable tap: fill 1..8, then sweep Addr with the clock enable off.
    for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, 8'(k), 4'h0);
    ce = 1'b0;
    addr = 4'd0;  #1; chk("var_addr0",  ifE.Q, 8'd8);
    addr = 4'd7;  #1; chk("var_addr7",  ifE.Q, 8'd1);
    addr = 4'd15; #1; chk("var_clamp",  ifE.Q, 8'd1);
    addr = 4'd3;  #1; chk("var_addr3",  ifE.Q, 8'd5);

    // Single-cycle pulse through fixed depth 4 with registered output.
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'h00, 4'h0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b1, (k == 1) ? 8'hFF : 8'h00, 4'h0);
      chk($sformatf("pulse_D_e%0d", k), ifD.Q, (k == 5) ? 8'hFF : 8'h00);
    end

    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           8'($urandom), 4'($urandom));

    // Reset with enable low clears the output register; stage data then resumes.
    for (int k = 0; k < 17; k++) step(1'b0, 1'b1, 8'($urandom_range(1, 255)), 4'h0);
    step(1'b1, 1'b0, 8'h00, 4'h0);
    chk("rst_noce_A", ifA.Q, 8'h00);
    chk("rst_noce_D", ifD.Q, 8'h00);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'($urandom), 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
